// File: rtl/rotate_iter_unit.sv
// Iterative ROL/ROR/RCL/RCR unit: one bit position per clock, CL-style count.
// Optional ROT_MASK_EN masks the count to 5 bits (80186 style); default uses the full 8-bit count.
module rotate_iter_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [7:0]       B,
  input  logic [1:0]       op,
  input  logic             cf_in,
  output logic [WIDTH-1:0] R,
  output logic             CF,
  output logic             OF,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_ROR = 2'b01;
  localparam logic [1:0] OP_RCL = 2'b10;

  state_t           state, state_d;
  logic [7:0]       cnt, cnt_d, eff_cnt;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] r_d, rot_r;
  logic             cf_d, of_d, rot_cf;

`ifdef ROT_MASK_EN
  assign eff_cnt = {3'b000, B[4:0]};
`else
  assign eff_cnt = B;
`endif

  // Single-bit step of the selected rotate on the current R/CF.
  always_comb begin
    rot_r  = R;
    rot_cf = CF;
    case (op_q)
      OP_ROL: begin rot_cf = R[WIDTH-1]; rot_r = {R[WIDTH-2:0], R[WIDTH-1]}; end
      OP_ROR: begin rot_cf = R[0];       rot_r = {R[0], R[WIDTH-1:1]};       end
      OP_RCL: begin rot_cf = R[WIDTH-1]; rot_r = {R[WIDTH-2:0], CF};         end
      default: begin rot_cf = R[0];      rot_r = {CF, R[WIDTH-1:1]};         end
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_d    = op_q;
    r_d     = R;
    cf_d    = CF;
    of_d    = OF;
    case (state)
      IDLE: begin
        if (start) begin
          r_d   = A;
          cf_d  = cf_in;
          op_d  = op;
          cnt_d = eff_cnt;
          if (eff_cnt == 8'd0) begin
            of_d    = 1'b0;
            state_d = FIN;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = rot_r;
        cf_d  = rot_cf;
        cnt_d = cnt - 8'd1;
        // OF is resolved on the last step so it is valid alongside done.
        if (cnt == 8'd1) begin
          state_d = FIN;
          of_d    = op_q[0] ? (rot_r[WIDTH-1] ^ rot_r[WIDTH-2])
                            : (rot_r[WIDTH-1] ^ rot_cf);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      R     <= '0;
      CF    <= 1'b0;
      OF    <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      op_q  <= op_d;
      R     <= r_d;
      CF    <= cf_d;
      OF    <= of_d;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);

endmodule

// File: tb/tb_rotate_iter_unit.sv
// Bench for rotate_iter_unit: directed cases plus random ops against a whole-rotation reference model.
module tb_rotate_iter_unit;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [7:0]   B = '0;
  logic [1:0]   op = '0;
  logic         cf_in = 1'b0;
  logic [W-1:0] R;
  logic         CF, OF, busy, done;

  int checks = 0;
  int errors = 0;

  rotate_iter_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .op(op),
    .cf_in(cf_in), .R(R), .CF(CF), .OF(OF), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_count(input logic [7:0] b);
`ifdef ROT_MASK_EN
    return int'(b[4:0]);
`else
    return int'(b);
`endif
  endfunction

  // Whole rotation at once: ROL/ROR over W bits, RCL/RCR over the (W+1)-bit {CF,A} ring.
  task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [7:0] b,
                       input logic c, output logic [W-1:0] er, output logic ecf, output logic eof);
    int n, m;
    logic [63:0] v, res;
    n = eff_count(b);
    if (n == 0) begin
      er = a; ecf = c; eof = 1'b0;
      return;
    end
    if (o[1] == 1'b0) begin
      m = n % W;
      v = 64'(a);
      if (o[0] == 1'b0) res = ((v << m) | (v >> (W - m))) & 64'hFFFF;
      else              res = ((v >> m) | (v << (W - m))) & 64'hFFFF;
      er  = res[W-1:0];
      ecf = o[0] ? er[W-1] : er[0];
    end else begin
      m = n % (W + 1);
      v = {47'd0, c, a};
      if (o[0] == 1'b0) res = ((v << m) | (v >> (W + 1 - m))) & 64'h1FFFF;
      else              res = ((v >> m) | (v << (W + 1 - m))) & 64'h1FFFF;
      er  = res[W-1:0];
      ecf = res[W];
    end
    eof = o[0] ? (er[W-1] ^ er[W-2]) : (er[W-1] ^ ecf);
  endtask

  // Issue one op at a negedge, optionally pulse a stray start at cycle 'poke', then check.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [7:0] b, input logic c, input int poke);
    logic [W-1:0] er;
    logic ecf, eof;
    int lat;
    bit seen_busy_drop;
    model(o, a, b, c, er, ecf, eof);
    op = o; A = a; B = b; cf_in = c; start = 1'b1;
    lat = 0;
    seen_busy_drop = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (lat == poke) begin
        start = 1'b1; A = ~a; B = 8'd3; op = ~o; cf_in = ~c;
      end else begin
        start = 1'b0;
      end
      if (!busy) seen_busy_drop = 1;
      if (done) break;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(eff_count(b) + 1));
    chk({tag, "_busy_until_done"}, 32'(seen_busy_drop), 32'd0);
    chk({tag, "_R"}, 32'(R), 32'(er));
    chk({tag, "_CF"}, 32'(CF), 32'(ecf));
    chk({tag, "_OF"}, 32'(OF), 32'(eof));
    @(negedge clk);
    chk({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] hr;
    logic hcf, hof;
    #2;
    chk("reset_outs", {12'd0, R, CF, OF, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("t1_rol", 2'b00, 16'h8001, 8'd1, 1'b0, 0);
    do_op("t2_rcr", 2'b11, 16'h0001, 8'd1, 1'b0, 0);
    do_op("t3_rcl17", 2'b10, 16'h8000, 8'd17, 1'b1, 0);
    do_op("t4_ror0", 2'b01, 16'hBEEF, 8'd0, 1'b1, 0);
    do_op("t6_rol33", 2'b00, 16'h1234, 8'h21, 1'b0, 0);
    do_op("ror_w16", 2'b01, 16'hA5C3, 8'd16, 1'b0, 0);
    do_op("rcr_max", 2'b11, 16'h8421, 8'd255, 1'b1, 0);
    do_op("stray_start", 2'b10, 16'h0F0F, 8'd6, 1'b0, 3);

    // Outputs hold in IDLE while inputs wander without start.
    hr = R; hcf = CF; hof = OF;
    A = 16'h5555; B = 8'd9; op = 2'b01; cf_in = ~hcf;
    repeat (3) @(negedge clk);
    chk("hold_idle", {15'd0, R, CF, OF}, {15'd0, hr, hcf, hof});

    // Abort mid-run with async reset, then a fresh op must complete.
    op = 2'b00; A = 16'h1357; B = 8'd10; cf_in = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; A = 16'hFFFF;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("t5_running", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("t5_abort", {12'd0, R, CF, OF, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("t5_fresh", 2'b00, 16'h1357, 8'd10, 1'b1, 0);

    for (int i = 0; i < 24; i++) begin
      logic [7:0] rb;
      rb = (i % 6 == 5) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      do_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), W'($urandom), rb,
            1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
